adder_share_arb: RTL

Round-robin arbiter and sequencer that shares one external `adder_rca` instance (WIDTH-bit, no carry-in) between NREQ independent requesters. Each requester presents an operand pair with a valid/ready handshake. The block registers the granted operands and drives them into the shared adder, then captures sum and carry-out. It returns the result on a single tagged response channel with valid/ready handshake. It sits between the requesting datapath units and the adder instance.

---
 rtl/adder_share_arb.sv | 137 +++++++++++++
 1 files changed

// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one external ripple-carry adder among NREQ requesters.
// Optional carry-out counter enabled by define ADDER_ARB_OVF_CNT_EN (ovf_cnt tied to 0 otherwise).
// Latency: accept edge -> CALC -> RESP; rsp_ready low holds RESP and blocks new grants.
module adder_share_arb #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  input  logic [WIDTH-1:0]      add_sum,
  input  logic                  add_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic [15:0]           ovf_cnt
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             gnt_vld;
  logic [IDW-1:0]   gnt_idx;

  // Scan from farthest to nearest offset so the lowest offset after ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[(int'(ptr_q) + k) % NREQ]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          req_ready[gnt_idx] = 1'b1;
          opa_d   = req_a[gnt_idx*WIDTH +: WIDTH];
          opb_d   = req_b[gnt_idx*WIDTH +: WIDTH];
          id_d    = gnt_idx;
          state_d = CALC;
        end
      end
      CALC: begin
        sum_d   = add_sum;
        cout_d  = add_cout;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          ptr_d   = id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(NREQ - 1);
      id_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign add_a     = opa_q;
  assign add_b     = opb_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;

`ifdef ADDER_ARB_OVF_CNT_EN
  logic [15:0] ovf_q, ovf_d;

  // Counts at the same edge the result is captured; sticks at all-ones.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == CALC && add_cout && ovf_q != 16'hFFFF) begin
      ovf_d = ovf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_cnt = ovf_q;
`else
  assign ovf_cnt = '0;
`endif

endmodule
